// File: rtl/bus_sequencer.sv
// Fetch/decode/execute control for the 8-bit common bus of the 16-word accumulator machine.
// Optional macro STEP_EN: each instruction ends in IDLE, so every start pulse runs exactly one instruction.
module bus_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       ir,
    output logic [2:0]       bus_sel,
    output logic             ar_ld,
    output logic             pc_ld,
    output logic             pc_inc,
    output logic             dr_ld,
    output logic             ac_ld,
    output logic             ir_ld,
    output logic             mem_we,
    output logic [1:0]       alu_op,
    output logic             halted,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_D,
        S_E0,
        S_E1,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] BUS_ZERO = 3'b000;
    localparam logic [2:0] BUS_AR   = 3'b001;
    localparam logic [2:0] BUS_PC   = 3'b010;
    localparam logic [2:0] BUS_DR   = 3'b011;
    localparam logic [2:0] BUS_AC   = 3'b100;
    localparam logic [2:0] BUS_IR   = 3'b101;
    localparam logic [2:0] BUS_RAM  = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

`ifdef STEP_EN
    localparam state_t S_AFTER = S_IDLE;
`else
    localparam state_t S_AFTER = S_F0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       op;
    logic [3:0]       op_dec;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op    <= 4'h0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_D) begin
                op <= ir[7:4];
            end
            if (instr_done) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // In D the opcode is still on ir; from E0 onward only the latched copy counts.
    always_comb begin
        state_nxt  = state;
        bus_sel    = BUS_ZERO;
        ar_ld      = 1'b0;
        pc_ld      = 1'b0;
        pc_inc     = 1'b0;
        dr_ld      = 1'b0;
        ac_ld      = 1'b0;
        ir_ld      = 1'b0;
        mem_we     = 1'b0;
        alu_op     = ALU_PASS;
        halted     = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        op_dec     = (state == S_D) ? ir[7:4] : op;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_F0;
                end
            end
            S_F0: begin
                bus_sel   = BUS_PC;
                ar_ld     = 1'b1;
                state_nxt = S_F1;
            end
            S_F1: begin
                bus_sel   = BUS_RAM;
                ir_ld     = 1'b1;
                pc_inc    = 1'b1;
                state_nxt = S_D;
            end
            S_D: begin
                bus_sel = BUS_IR;
                ar_ld   = 1'b1;
                case (op_dec)
                    OP_NOP: begin
                        instr_done = 1'b1;
                        state_nxt  = S_AFTER;
                    end
                    OP_HLT: begin
                        instr_done = 1'b1;
                        state_nxt  = S_HALT;
                    end
                    OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_JMP: begin
                        state_nxt = S_E0;
                    end
                    default: begin
                        instr_done = 1'b1;
                        illegal    = 1'b1;
                        state_nxt  = S_AFTER;
                    end
                endcase
            end
            S_E0: begin
                case (op_dec)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        bus_sel   = BUS_RAM;
                        dr_ld     = 1'b1;
                        state_nxt = S_E1;
                    end
                    OP_STA: begin
                        bus_sel    = BUS_AC;
                        mem_we     = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_AFTER;
                    end
                    OP_JMP: begin
                        bus_sel    = BUS_AR;
                        pc_ld      = 1'b1;
                        instr_done = 1'b1;
                        state_nxt  = S_AFTER;
                    end
                    default: begin
                        state_nxt = S_AFTER;
                    end
                endcase
            end
            S_E1: begin
                bus_sel    = BUS_DR;
                ac_ld      = 1'b1;
                instr_done = 1'b1;
                state_nxt  = S_AFTER;
                case (op_dec)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    default: alu_op = ALU_PASS;
                endcase
            end
            S_HALT: begin
                halted = 1'b1;
                if (start) begin
                    state_nxt = S_F0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr_cnt = cnt;

endmodule
